// File: rtl/regfile_param_if.sv
// Register-file port bundle: read addresses, write port, soft clear,
// registered read data and the busy flag.
// The decoder/writeback side uses the master modport and the register file uses the slave modport.
interface regfile_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] data;
    logic              reg_write;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              busy;

    modport master (
        output clr, rr1, rr2, wr, data, reg_write,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  clr, rr1, rr2, wr, data, reg_write,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: DEPTH = 2^ADDR_W entries of DATA_W bits.
// The register file has two registered read ports and one write port.
// After rst, or after a soft clear, an initialisation walk loads entry[i] = i.
// Optional build macro REGFILE_BYPASS_EN: when it is defined, a write that
// collides with a read on the same edge is forwarded to that read port.
// Without the macro, a colliding read returns the old contents.
// The storage array has no reset, so it can map onto block RAM.
// Each read port registers the raw RAM word and also registers a small
// source-select code that has an async reset. The output mux then picks
// zero, the RAM word, or the forwarded write data. Because of this, rdataN
// reads as 0 immediately after rst.
module regfile_param #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NPORT = 2;
    localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // Source of a read port's output for the cycle after an edge.
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_BYP
    } sel_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   idx_reg, idx_next;
    logic              busy_reg, busy_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A normal-operation write that will land in storage this edge.
    logic              wr_accept;

    logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
    logic [NPORT-1:0][DATA_W-1:0] rd_data;
    logic [NPORT-1:0]             byp_hit;

    assign rd_addr[0] = bus.rr1;
    assign rd_addr[1] = bus.rr2;

    assign bus.rdata1 = rd_data[0];
    assign bus.rdata2 = rd_data[1];
    assign bus.busy   = busy_reg;

    // Sequencer state, walk index and busy flag; rst aborts instantly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state logic: the walk ends on the edge that writes entry DEPTH-1,
    // and clr restarts the walk from either state.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            ST_INIT: begin
                if (bus.clr) begin
                    idx_next = '0;
                end else if (idx_reg == IDX_LAST) begin
                    state_next = ST_READY;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + IDX_ONE;
                end
            end
            ST_READY: begin
                if (bus.clr) begin
                    state_next = ST_INIT;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                idx_next   = '0;
            end
        endcase
        busy_next = (state_next == ST_INIT);
    end

    // Write port selection.
    // During the walk, the sequencer owns the write port.
    // In normal operation, the write port follows reg_write.
    // A clr on the same edge discards either kind of write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr;
        mem_wdata = bus.data;
        wr_accept = 1'b0;
        if (!bus.clr) begin
            if (state_reg == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = idx_reg[ADDR_W-1:0];
                if (ZERO_REG && (idx_reg == '0)) begin
                    mem_wdata = '0;
                end else begin
                    mem_wdata = DATA_W'(idx_reg[ADDR_W-1:0]);
                end
            end else if (bus.reg_write && !(ZERO_REG && (bus.wr == '0))) begin
                mem_we    = 1'b1;
                wr_accept = 1'b1;
            end
        end
    end

    // Storage array: a single synchronous write port with no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Copy of the write data, kept for forwarding to a colliding read port.
    logic [DATA_W-1:0] byp_data_reg;

    // Capture the write data every edge; it is used only when a port selected bypass.
    always_ff @(posedge clk) begin
        byp_data_reg <= bus.data;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi = gi + 1) begin : g_rd_port
            logic [DATA_W-1:0] raw_reg;
            sel_t              sel_reg;
            sel_t              sel_next;

`ifdef REGFILE_BYPASS_EN
            assign byp_hit[gi] = wr_accept && (bus.wr == rd_addr[gi]);
`else
            assign byp_hit[gi] = 1'b0;
`endif

            // Registered RAM read. This register has no reset, so it can be absorbed into block RAM.
            always_ff @(posedge clk) begin
                raw_reg <= mem[rd_addr[gi]];
            end

            // Pick the output source for the cycle after this edge.
            always_comb begin
                sel_next = SEL_RAM;
                if (state_reg == ST_INIT) begin
                    sel_next = SEL_ZERO;
                end else if (ZERO_REG && (rd_addr[gi] == '0)) begin
                    sel_next = SEL_ZERO;
                end else if (byp_hit[gi]) begin
                    sel_next = SEL_BYP;
                end
            end

            // Source select register. Its async reset forces the output to 0 right away.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sel_reg <= SEL_ZERO;
                end else begin
                    sel_reg <= sel_next;
                end
            end

            // Output mux driven by the registered select code.
            always_comb begin
                rd_data[gi] = '0;
                unique case (sel_reg)
                    SEL_RAM: rd_data[gi] = raw_reg;
`ifdef REGFILE_BYPASS_EN
                    SEL_BYP: rd_data[gi] = byp_data_reg;
`endif
                    default: rd_data[gi] = '0;
                endcase
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (DATA_W=64, ADDR_W=5, ZERO_REG=1).
// A behavioural array model tracks the register contents.
// Expected read values are derived from the architectural rules.
module tb_regfile_param;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 32;
    localparam bit ZERO_REG = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];

    regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    regfile_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.clr       = 1'b0;
        bus_if.reg_write = 1'b0;
        bus_if.wr        = '0;
        bus_if.data      = '0;
        bus_if.rr1       = '0;
        bus_if.rr2       = '0;
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = (ZERO_REG && i == 0) ? 64'd0 : 64'(i);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input int addr, input bit we,
                                                  input int waddr,
                                                  input logic [DATA_W-1:0] wdata);
        if (ZERO_REG && addr == 0) return '0;
        if (BYP && we && waddr == addr && !(ZERO_REG && waddr == 0)) return wdata;
        return model_mem[addr];
    endfunction

    task automatic model_write(input bit we, input int waddr, input logic [DATA_W-1:0] wdata);
        if (we && !(ZERO_REG && waddr == 0)) model_mem[waddr] = wdata;
    endtask

    // Step until busy drops. It must take exactly DEPTH edges.
    // rdata must read 0 throughout the walk.
    task automatic wait_init(input string name);
        int n;
        bit rd_ok;
        n = 0;
        rd_ok = 1'b1;
        bus_if.rr1 = 5'd3;
        bus_if.rr2 = 5'd5;
        do begin
            step();
            n++;
            if (bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) rd_ok = 1'b0;
        end while (bus_if.busy === 1'b1 && n < 200);
        checks++;
        if (n !== DEPTH) begin
            failures++;
            $display("FAIL %s init_len got=%0d exp=%0d", name, n, DEPTH);
        end
        checks++;
        if (!rd_ok) begin
            failures++;
            $display("FAIL %s init_rdata_nonzero", name);
        end
        $display("%s: init walk %0d edges", name, n);
        model_init();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b rdata1=%h rdata2=%h exp busy=1 rdata=0",
                     bus_if.busy, bus_if.rdata1, bus_if.rdata2);
        end
        $display("reset: busy=%b rdata1=%h rdata2=%h", bus_if.busy, bus_if.rdata1, bus_if.rdata2);
        rst = 1'b0;
        wait_init("reset");
    endtask

    task automatic test_init_contents();
        bus_if.rr1 = 5'd7;
        bus_if.rr2 = 5'd31;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'd7 || bus_if.rdata2 !== 64'd31) begin
            failures++;
            $display("FAIL init_read_7_31 got=%h,%h exp=7,31", bus_if.rdata1, bus_if.rdata2);
        end
        $display("read rr1=7 rr2=31 -> %h %h", bus_if.rdata1, bus_if.rdata2);
        bus_if.rr1 = 5'd0;
        step();
        checks++;
        if (bus_if.rdata1 !== '0) begin
            failures++;
            $display("FAIL init_read_0 got=%h exp=0", bus_if.rdata1);
        end
        $display("read rr1=0 -> %h", bus_if.rdata1);
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.rr1 = 5'(i);
            bus_if.rr2 = 5'(DEPTH - 1 - i);
            step();
            checks++;
            if (bus_if.rdata1 !== model_mem[i] || bus_if.rdata2 !== model_mem[DEPTH-1-i]) begin
                failures++;
                $display("FAIL init_entry_%0d got=%h,%h exp=%h,%h", i, bus_if.rdata1,
                         bus_if.rdata2, model_mem[i], model_mem[DEPTH-1-i]);
            end
        end
        $display("init contents: %0d entries read", DEPTH);
    endtask

    task automatic test_write();
        bus_if.wr        = 5'd5;
        bus_if.data      = 64'hDEAD_BEEF;
        bus_if.reg_write = 1'b1;
        step();
        bus_if.reg_write = 1'b0;
        bus_if.rr1       = 5'd5;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_read5 got=%h exp=deadbeef", bus_if.rdata1);
        end
        $display("write wr=5 data=deadbeef, read -> %h", bus_if.rdata1);
        model_mem[5] = 64'hDEAD_BEEF;
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp2;
        bus_if.wr        = 5'd9;
        bus_if.rr2       = 5'd9;
        bus_if.rr1       = 5'd10;
        bus_if.data      = 64'h1234;
        bus_if.reg_write = 1'b1;
        step();
        exp2 = BYP ? 64'h1234 : 64'd9;
        checks++;
        if (bus_if.rdata2 !== exp2 || bus_if.rdata1 !== 64'd10) begin
            failures++;
            $display("FAIL collision_same_edge got=%h,%h exp=%h,%h", bus_if.rdata2,
                     bus_if.rdata1, exp2, 64'd10);
        end
        $display("collision wr=rr2=9: same edge rdata2=%h", bus_if.rdata2);
        bus_if.reg_write = 1'b0;
        step();
        checks++;
        if (bus_if.rdata2 !== 64'h1234) begin
            failures++;
            $display("FAIL collision_next got=%h exp=1234", bus_if.rdata2);
        end
        $display("collision next edge rdata2=%h", bus_if.rdata2);
        model_mem[9] = 64'h1234;
    endtask

    task automatic test_zero_reg();
        bus_if.wr        = 5'd0;
        bus_if.data      = 64'hFF;
        bus_if.rr1       = 5'd0;
        bus_if.rr2       = 5'd0;
        bus_if.reg_write = 1'b1;
        step();
        checks++;
        if (bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
            failures++;
            $display("FAIL zero_collide got=%h,%h exp=0,0", bus_if.rdata1, bus_if.rdata2);
        end
        bus_if.reg_write = 1'b0;
        step();
        checks++;
        if (bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
            failures++;
            $display("FAIL zero_read got=%h,%h exp=0,0", bus_if.rdata1, bus_if.rdata2);
        end
        $display("write ff to r0, read r0 -> %h %h", bus_if.rdata1, bus_if.rdata2);
    endtask

    task automatic test_random();
        int a1, a2, wa;
        bit we;
        logic [DATA_W-1:0] d, e1, e2;
        for (int k = 0; k < 300; k++) begin
            a1 = $urandom_range(0, DEPTH - 1);
            a2 = $urandom_range(0, DEPTH - 1);
            wa = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 3) == 0) wa = a1;
            if ($urandom_range(0, 3) == 0) wa = a2;
            we = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            e1 = exp_read(a1, we, wa, d);
            e2 = exp_read(a2, we, wa, d);
            model_write(we, wa, d);
            bus_if.rr1       = 5'(a1);
            bus_if.rr2       = 5'(a2);
            bus_if.wr        = 5'(wa);
            bus_if.data      = d;
            bus_if.reg_write = we;
            step();
            checks++;
            if (bus_if.rdata1 !== e1 || bus_if.rdata2 !== e2 || bus_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d got=%h,%h busy=%b exp=%h,%h busy=0", k,
                         bus_if.rdata1, bus_if.rdata2, bus_if.busy, e1, e2);
            end
            $display("rand %0d: rr1=%0d rr2=%0d we=%0d wr=%0d -> %h %h", k, a1, a2, we, wa,
                     bus_if.rdata1, bus_if.rdata2);
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid();
        // Apply rst asynchronously during operation, while rdata1 holds a nonzero value.
        bus_if.rr1 = 5'd7;
        bus_if.rr2 = 5'd9;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
            failures++;
            $display("FAIL rst_mid_op busy=%b rdata=%h,%h exp busy=1 rdata=0", bus_if.busy,
                     bus_if.rdata1, bus_if.rdata2);
        end
        $display("rst mid-operation: busy=%b rdata1=%h", bus_if.busy, bus_if.rdata1);
        step();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 12; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
            failures++;
            $display("FAIL rst_mid_init busy=%b rdata=%h,%h exp busy=1 rdata=0", bus_if.busy,
                     bus_if.rdata1, bus_if.rdata2);
        end
        $display("rst at idx=12: busy=%b", bus_if.busy);
        step();
        rst = 1'b0;
        wait_init("rst_mid_init");
    endtask

    task automatic test_clr();
        bus_if.wr        = 5'd3;
        bus_if.data      = 64'hAA;
        bus_if.reg_write = 1'b1;
        step();
        bus_if.reg_write = 1'b0;
        bus_if.rr1       = 5'd3;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'hAA) begin
            failures++;
            $display("FAIL clr_pre_write got=%h exp=aa", bus_if.rdata1);
        end
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_busy got=%b exp=1", bus_if.busy);
        end
        $display("clr in READY: busy=%b", bus_if.busy);
        wait_init("clr");
        bus_if.rr1 = 5'd3;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'd3) begin
            failures++;
            $display("FAIL clr_entry3 got=%h exp=3", bus_if.rdata1);
        end
        $display("after clr entry 3 -> %h", bus_if.rdata1);
    endtask

    task automatic test_clr_write();
        bus_if.clr       = 1'b1;
        bus_if.reg_write = 1'b1;
        bus_if.wr        = 5'd4;
        bus_if.data      = 64'h55;
        step();
        idle_inputs();
        wait_init("clr_write");
        bus_if.rr1 = 5'd4;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'd4) begin
            failures++;
            $display("FAIL clr_write_entry4 got=%h exp=4", bus_if.rdata1);
        end
        $display("clr+write wr=4: entry 4 -> %h", bus_if.rdata1);
    endtask

    task automatic test_clr_in_init();
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        wait_init("clr_in_init");
        bus_if.rr1 = 5'd20;
        bus_if.rr2 = 5'd31;
        step();
        checks++;
        if (bus_if.rdata1 !== 64'd20 || bus_if.rdata2 !== 64'd31) begin
            failures++;
            $display("FAIL clr_in_init_read got=%h,%h exp=20,31", bus_if.rdata1, bus_if.rdata2);
        end
        $display("clr during INIT: read 20,31 -> %h %h", bus_if.rdata1, bus_if.rdata2);
    endtask

    initial begin
        idle_inputs();
        model_init();
        test_reset();
        test_init_contents();
        test_write();
        test_collision();
        test_zero_reg();
        test_random();
        test_rst_mid();
        test_clr();
        test_clr_write();
        test_clr_in_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the CPU's 32×64 register file. It holds DEPTH = 2^ADDR_W entries of DATA_W bits, with two registered read ports and one write port. A reset-driven initialisation sequencer loads every entry with its own index, and the same sequence can be restarted by a soft clear. Sits in the decode stage between the instruction decoder (register addresses) and the ALU/writeback path.

## Interface
- DATA_W, 64, entry and data-port width
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- ZERO_REG, 1, when 1: entry 0 reads as 0 and writes to it are dropped
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  soft clear, synchronous; restarts the initialisation sequence
- rr1  in  ADDR_W  read address, port 1
- rr2  in  ADDR_W  read address, port 2
- wr  in  ADDR_W  write address
- data  in  DATA_W  write data
- reg_write  in  1  write enable
- rdata1  out  DATA_W  registered read data, port 1
- rdata2  out  DATA_W  registered read data, port 2
- busy  out  1  high while the initialisation sequence runs; reads and writes are not serviced

## Operation
- Decided: one clock (clk); reset rst is asynchronous and active-high.
- Storage has no reset; contents are defined only through the INIT sequencer.
- FSM has two states:
  - INIT: a counter idx of ADDR_W+1 bits walks 0..DEPTH-1. Each edge writes entry[idx] = idx, zero-extended to DATA_W. When idx = 0 and ZERO_REG = 1, the written value is 0.
  - READY: normal operation.
- INIT → READY on the edge that writes entry DEPTH-1.
- READY → INIT on any edge with clr = 1; idx is set to 0.
- clr = 1 while in INIT restarts the walk at idx = 0.
- In INIT:
  - reg_write is ignored.
  - rdata1 and rdata2 are loaded with 0 each edge.
  - busy = 1.
- In READY, write behaviour:
  - If reg_write = 1, then entry[wr] <= data.
  - The write is dropped if wr = 0 and ZERO_REG = 1.
- In READY, read behaviour:
  - Each edge, rdataN <= entry[rrN].
  - rdataN is forced to 0 if rrN = 0 and ZERO_REG = 1.
- Both read ports are independent, and the same address on both ports is legal.
- Write/read collision (reg_write = 1 and wr = rrN on the same edge): governed by the configuration macro below.
- busy is a registered output: 1 in INIT, 0 in READY.

## Timing
- Reset values:
  - state = INIT, idx = 0.
  - rdata1 = rdata2 = 0.
  - busy = 1.
- Asserting rst mid-sequence or mid-operation aborts immediately. Storage contents are left as-is and are overwritten by the new INIT walk.
- INIT length: exactly DEPTH rising edges after rst deasserts (edges 1..DEPTH). busy falls after edge DEPTH. The first serviced read or write is on edge DEPTH+1.
- Read latency: 1 cycle. Address presented before edge k gives data valid after edge k.
- Write latency: 1 cycle. Data written at edge k is visible to a read sampled at edge k+1 (result valid after k+1).
- clr has priority over reg_write on the same edge; the write is discarded.
- rst has priority over everything.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding.
  - In READY, if reg_write = 1 and wr = rrN, with wr ≠ 0 or ZERO_REG = 0, then rdataN <= data on that edge.
  - This gives zero-bubble read-after-write.
- REGFILE_BYPASS_EN not defined: read-before-write. rdataN gets the old entry value on a colliding edge and the new value from the next edge on.
- ZERO_REG masking applies in both builds.

## Test plan
- Release rst:
  - busy = 1 for exactly 32 edges (ADDR_W = 5).
  - Then rr1 = 7, rr2 = 31 → rdata1 = 7, rdata2 = 31 one cycle later.
  - rr1 = 0 → 0.
- READY, write data = 64'hDEAD_BEEF to wr = 5, then rr1 = 5 next cycle → rdata1 = 64'hDEAD_BEEF.
- Collision, wr = rr2 = 9, data = 64'h1234:
  - With REGFILE_BYPASS_EN: rdata2 = 64'h1234 on the same edge.
  - Without it: rdata2 = 9, then 64'h1234 next cycle.
- With ZERO_REG = 1, write 64'hFF to wr = 0, read rr1 = rr2 = 0 → both 0.
- Mid-INIT and soft-clear checks:
  - Pulse rst at idx = 12: rdata1/2 = 0 and busy = 1 immediately; INIT takes a full 32 edges again.
  - Pulse clr in READY after writing entry 3 = 64'hAA: busy high for 32 edges, then entry 3 reads 3.
- clr and reg_write on the same edge (wr = 4, data = 64'h55): the write is discarded; after INIT, entry 4 reads 4.
